// File: rtl/riscv_mem_pkg.sv
// Shared types and helpers for the byte-wide memory arbiter.
// Holds the FSM state enum, funct3 codes, IO window base and load helpers.
package riscv_mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RD,
    WR
  } mem_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [31:0] IO_BASE = 32'h0003_0000;

  function automatic logic [2:0] mem_len(input logic [1:0] sz);
    case (sz)
      2'b00:   mem_len = 3'd1;
      2'b01:   mem_len = 3'd2;
      default: mem_len = 3'd4;
    endcase
  endfunction

  function automatic logic [31:0] load_ext(
    input logic [31:0] w,
    input logic [2:0]  f3
  );
    case (f3)
      F3_B:    load_ext = {{24{w[7]}}, w[7:0]};
      F3_H:    load_ext = {{16{w[15]}}, w[15:0]};
      F3_BU:   load_ext = {24'h0, w[7:0]};
      F3_HU:   load_ext = {16'h0, w[15:0]};
      default: load_ext = w;
    endcase
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Byte-wide RAM port arbiter between instruction fetch and the LSB.
// Splits accesses into byte cycles, assembles reads, stalls IO writes.
module mem_arbiter
  import riscv_mem_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        rollback_config,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_done,
  output logic [31:0] if_inst,
  input  logic        lsb_req,
  input  logic        lsb_ls,
  input  logic [31:0] lsb_addr,
  input  logic [31:0] lsb_data,
  input  logic [2:0]  lsb_precise,
  output logic        lsb_done,
  output logic [31:0] lsb_rdata,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full
);

  mem_state_e  state;
  logic [2:0]  cnt;
  logic [2:0]  len;
  logic [2:0]  nxt;
  logic [2:0]  f3;
  logic        own_lsb;
  logic        last_lsb;
  logic        wr_q;
  logic [31:0] base;
  logic [31:0] wdata;
  logic [31:0] rbuf;
  logic [31:0] word;
  logic        io_stall;
  logic        pick_lsb;
  logic        grant;

  assign nxt = cnt + 3'd1;

  assign io_stall = (mem_a[17:16] == IO_BASE[17:16]) && io_buffer_full;
  assign mem_wr   = wr_q && rdy && !io_stall;

  // A requester still sees its done pulse, so it must not be re-granted.
  assign pick_lsb = lsb_req && (!if_req || !last_lsb);
  assign grant    = (if_req || lsb_req) && !if_done && !lsb_done
                    && !rollback_config;

  // Byte cnt-1 arrives on mem_din while cnt counts issued addresses.
  always_comb begin
    word = rbuf;
    case (cnt)
      3'd1:    word[7:0]   = mem_din;
      3'd2:    word[15:8]  = mem_din;
      3'd3:    word[23:16] = mem_din;
      3'd4:    word[31:24] = mem_din;
      default: word        = rbuf;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 3'd0;
      len       <= 3'd0;
      f3        <= 3'd0;
      own_lsb   <= 1'b0;
      last_lsb  <= 1'b0;
      wr_q      <= 1'b0;
      base      <= 32'h0;
      wdata     <= 32'h0;
      rbuf      <= 32'h0;
      mem_a     <= 32'h0;
      mem_dout  <= 8'h0;
      if_done   <= 1'b0;
      lsb_done  <= 1'b0;
      if_inst   <= 32'h0;
      lsb_rdata <= 32'h0;
    end else if (rdy) begin
      if_done  <= 1'b0;
      lsb_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (grant) begin
            last_lsb <= pick_lsb;
            own_lsb  <= pick_lsb;
            cnt      <= 3'd0;
            rbuf     <= 32'h0;
            if (pick_lsb) begin
              base  <= lsb_addr;
              mem_a <= lsb_addr;
              f3    <= lsb_precise;
              len   <= mem_len(lsb_precise[1:0]);
              if (lsb_ls) begin
                state <= RD;
              end else begin
                state    <= WR;
                wr_q     <= 1'b1;
                wdata    <= lsb_data;
                mem_dout <= lsb_data[7:0];
              end
            end else begin
              base  <= if_addr;
              mem_a <= if_addr;
              f3    <= F3_W;
              len   <= 3'd4;
              state <= RD;
            end
          end
        end
        RD: begin
          if (rollback_config) begin
            state <= IDLE;
            cnt   <= 3'd0;
          end else begin
            rbuf <= word;
            cnt  <= nxt;
            if (cnt == len) begin
              state <= IDLE;
              cnt   <= 3'd0;
              if (own_lsb) begin
                lsb_done  <= 1'b1;
                lsb_rdata <= load_ext(word, f3);
              end else begin
                if_done <= 1'b1;
                if_inst <= word;
              end
            end else if (nxt < len) begin
              mem_a <= base + {29'h0, nxt};
            end
          end
        end
        WR: begin
          if (!io_stall) begin
            if (cnt == len - 3'd1) begin
              state    <= IDLE;
              cnt      <= 3'd0;
              wr_q     <= 1'b0;
              lsb_done <= 1'b1;
            end else begin
              cnt      <= nxt;
              mem_a    <= base + {29'h0, nxt};
              mem_dout <= wdata[{nxt[1:0], 3'b000} +: 8];
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter against a transaction-level RAM model.
// Checks latency, data, write counts, arbitration order and RAM contents.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        rollback_config;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_done;
  logic [31:0] if_inst;
  logic        lsb_req;
  logic        lsb_ls;
  logic [31:0] lsb_addr;
  logic [31:0] lsb_data;
  logic [2:0]  lsb_precise;
  logic        lsb_done;
  logic [31:0] lsb_rdata;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .rollback_config(rollback_config),
    .if_req(if_req), .if_addr(if_addr),
    .if_done(if_done), .if_inst(if_inst),
    .lsb_req(lsb_req), .lsb_ls(lsb_ls),
    .lsb_addr(lsb_addr), .lsb_data(lsb_data),
    .lsb_precise(lsb_precise),
    .lsb_done(lsb_done), .lsb_rdata(lsb_rdata),
    .mem_din(mem_din), .mem_dout(mem_dout),
    .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full)
  );

  logic [7:0]  ram     [0:65535];
  logic [7:0]  ref_mem [0:65535];
  logic        clr;
  logic        pre_we;
  logic [31:0] pre_a;
  logic [7:0]  pre_d;
  int          wr_cycles;
  int          ifd_cnt;
  int          n_chk = 0;
  int          n_fail = 0;

  function automatic int idx(input logic [31:0] a);
    return int'({a[17:16], a[13:0]});
  endfunction

  // Synchronous RAM: one-cycle read latency, write on mem_wr.
  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 65536; i++) ram[i] <= 8'h00;
      wr_cycles <= 0;
      ifd_cnt   <= 0;
    end else begin
      mem_din <= ram[idx(mem_a)];
      if (mem_wr) ram[idx(mem_a)] <= mem_dout;
      if (pre_we) ram[idx(pre_a)] <= pre_d;
      if (mem_wr) wr_cycles <= wr_cycles + 1;
      if (if_done) ifd_cnt <= ifd_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input logic [31:0] a, input logic [7:0] d);
    pre_a  = a;
    pre_d  = d;
    pre_we = 1'b1;
    tick();
    pre_we = 1'b0;
    ref_mem[idx(a)] = d;
  endtask

  function automatic int nbytes(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] a,
                                           input logic [2:0] f3);
    int n;
    logic [31:0] v;
    n = nbytes(f3);
    v = 32'h0;
    for (int k = 0; k < n; k++)
      v = v | (32'(ref_mem[idx(a + 32'(k))]) << (8 * k));
    if (f3[2] == 1'b0 && n < 4 && v[8*n-1])
      v = v | ~((32'd1 << (8 * n)) - 32'd1);
    return v;
  endfunction

  task automatic lsb_txn(input bit ls, input logic [31:0] a,
                         input logic [31:0] d, input logic [2:0] f3,
                         input int stall, input int rb_at,
                         input int rdy_at);
    int n, lat, w0, el;
    logic [31:0] exp;
    bit io;
    n   = nbytes(f3);
    exp = ref_load(a, f3);
    io  = (a[17:16] == 2'b11);
    w0  = wr_cycles;
    lsb_ls = ls; lsb_addr = a; lsb_data = d; lsb_precise = f3;
    lsb_req = 1'b1;
    io_buffer_full = (stall > 0);
    lat = 0;
    while (!lsb_done && lat < 50) begin
      @(posedge clk);
      lat++;
      #1;
      io_buffer_full  = (lat <= stall);
      rollback_config = (rb_at > 0 && lat == rb_at);
      rdy = !(rdy_at > 0 && lat >= rdy_at && lat < rdy_at + 2);
      if (!rdy) begin
        #1;
        check("wr_rdy_low", 32'(mem_wr), 32'h0);
      end
    end
    if (ls) el = n + 2;
    else el = n + 1 + (io ? stall : 0) + (rdy_at > 0 ? 2 : 0);
    check(ls ? "ld_lat" : "st_lat", lat, el);
    if (ls) begin
      check("ld_data", lsb_rdata, exp);
    end else begin
      check("st_wr_cnt", wr_cycles - w0, n);
      for (int k = 0; k < n; k++)
        ref_mem[idx(a + 32'(k))] = d[8*k +: 8];
    end
    rollback_config = 1'b0;
    io_buffer_full  = 1'b0;
    rdy = 1'b1;
    tick();
    lsb_req = 1'b0;
    check("done_pulse", 32'(lsb_done), 32'h0);
  endtask

  task automatic if_txn(input logic [31:0] a);
    int lat;
    logic [31:0] exp;
    exp = ref_load(a, 3'b010);
    if_addr = a;
    if_req  = 1'b1;
    lat = 0;
    while (!if_done && lat < 50) begin
      tick();
      lat++;
    end
    check("if_lat", lat, 6);
    check("if_inst", if_inst, exp);
    tick();
    if_req = 1'b0;
  endtask

  initial begin
    int f0, w0, dn, mism, last;
    int oq[$];
    int eq[$];
    logic [2:0] ldf[5];
    logic [2:0] f3;
    logic [31:0] a, exp_l, exp_i;
    ldf = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

    rst = 1'b1; rdy = 1'b1; rollback_config = 1'b0;
    if_req = 1'b0; if_addr = 32'h0;
    lsb_req = 1'b0; lsb_ls = 1'b0; lsb_addr = 32'h0;
    lsb_data = 32'h0; lsb_precise = 3'b0;
    io_buffer_full = 1'b0;
    clr = 1'b1; pre_we = 1'b0; pre_a = 32'h0; pre_d = 8'h0;
    for (int i = 0; i < 65536; i++) ref_mem[i] = 8'h00;
    tick();
    clr = 1'b0;
    repeat (2) tick();
    rst = 1'b0;

    check("rst_if_done", 32'(if_done), 32'h0);
    check("rst_lsb_done", 32'(lsb_done), 32'h0);
    check("rst_mem_wr", 32'(mem_wr), 32'h0);
    check("rst_mem_a", mem_a, 32'h0);
    check("rst_mem_dout", 32'(mem_dout), 32'h0);
    check("rst_if_inst", if_inst, 32'h0);
    check("rst_lsb_rdata", lsb_rdata, 32'h0);

    for (int i = 0; i < 256; i++)
      poke(32'h1000 + 32'(i), 8'($urandom));
    poke(32'h100, 8'h78); poke(32'h101, 8'h56);
    poke(32'h102, 8'h34); poke(32'h103, 8'h12);
    poke(32'h110, 8'h80);
    poke(32'h120, 8'hFF); poke(32'h121, 8'h80);
    poke(32'h206, 8'h5A);
    for (int i = 0; i < 4; i++) begin
      poke(32'h300 + 32'(i), 8'($urandom));
      poke(32'h400 + 32'(i), 8'($urandom));
    end

    lsb_txn(1, 32'h100, 32'h0, 3'b010, 0, 0, 0);
    check("lw_const", lsb_rdata, 32'h12345678);
    lsb_txn(1, 32'h110, 32'h0, 3'b000, 0, 0, 0);
    check("lb_const", lsb_rdata, 32'hFFFFFF80);
    lsb_txn(1, 32'h110, 32'h0, 3'b100, 0, 0, 0);
    check("lbu_const", lsb_rdata, 32'h00000080);
    lsb_txn(1, 32'h120, 32'h0, 3'b101, 0, 0, 0);
    check("lhu_const", lsb_rdata, 32'h000080FF);

    lsb_txn(0, 32'h204, 32'hAABBCCDD, 3'b001, 0, 0, 0);
    check("sh_b0", 32'(ram[idx(32'h204)]), 32'hDD);
    check("sh_b1", 32'(ram[idx(32'h205)]), 32'hCC);
    check("sh_keep", 32'(ram[idx(32'h206)]), 32'h5A);

    lsb_txn(0, 32'h30000, 32'h41, 3'b000, 3, 0, 0);
    check("io_byte", 32'(ram[idx(32'h30000)]), 32'h41);

    f0 = ifd_cnt;
    w0 = wr_cycles;
    if_addr = 32'h400;
    if_req  = 1'b1;
    tick();
    tick();
    rollback_config = 1'b1;
    if_req = 1'b0;
    tick();
    rollback_config = 1'b0;
    lsb_txn(1, 32'h100, 32'h0, 3'b010, 0, 0, 0);
    check("rb_no_ifdone", ifd_cnt - f0, 0);
    check("rb_no_wr", wr_cycles - w0, 0);

    lsb_txn(0, 32'h208, 32'h11223344, 3'b010, 0, 2, 0);
    lsb_txn(0, 32'h600, 32'hCAFEBABE, 3'b010, 0, 0, 2);
    if_txn(32'h1004);

    lsb_ls = 1'b1; lsb_addr = 32'h1010; lsb_precise = 3'b010;
    lsb_req = 1'b1;
    repeat (3) tick();
    rst = 1'b1;
    lsb_req = 1'b0;
    tick();
    check("mid_rst_mem_a", mem_a, 32'h0);
    check("mid_rst_if_inst", if_inst, 32'h0);
    check("mid_rst_rdata", lsb_rdata, 32'h0);
    rst = 1'b0;
    dn = 0;
    repeat (8) begin
      tick();
      if (lsb_done) dn++;
    end
    check("mid_rst_no_done", dn, 0);

    exp_l = ref_load(32'h300, 3'b010);
    exp_i = ref_load(32'h400, 3'b010);
    lsb_ls = 1'b1; lsb_addr = 32'h300; lsb_precise = 3'b010;
    if_addr = 32'h400;
    lsb_req = 1'b1;
    if_req  = 1'b1;
    for (int t = 1; t <= 80 && oq.size() < 4; t++) begin
      tick();
      if (lsb_done) begin
        oq.push_back(1); eq.push_back(t);
        check("arb_lsb_data", lsb_rdata, exp_l);
      end
      if (if_done) begin
        oq.push_back(0); eq.push_back(t);
        check("arb_if_data", if_inst, exp_i);
      end
    end
    tick();
    lsb_req = 1'b0;
    if_req  = 1'b0;
    check("arb_count", oq.size(), 4);
    for (int i = 0; i < oq.size(); i++) begin
      check("arb_order", oq[i], (i % 2 == 0) ? 1 : 0);
      if (i > 0) check("arb_gap", eq[i] - eq[i-1], 7);
    end
    check("arb_first", eq.size() > 0 ? eq[0] : 0, 6);

    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 9) == 0) begin
        if_txn(32'h1000 + 32'(4 * $urandom_range(0, 63)));
      end else if ($urandom_range(0, 1) == 1) begin
        f3 = ldf[$urandom_range(0, 4)];
        a  = ($urandom_range(0, 3) == 0)
             ? 32'h30000 + 32'($urandom_range(0, 63))
             : 32'h1000 + 32'($urandom_range(0, 251));
        lsb_txn(1, a, 32'h0, f3, int'($urandom_range(0, 3)), 0, 0);
      end else begin
        f3 = 3'($urandom_range(0, 2));
        a  = ($urandom_range(0, 3) == 0)
             ? 32'h30000 + 32'($urandom_range(0, 63))
             : 32'h1000 + 32'($urandom_range(0, 251));
        lsb_txn(0, a, $urandom, f3, int'($urandom_range(0, 3)), 0, 0);
      end
    end

    mism = 0;
    last = -1;
    for (int i = 0; i < 65536; i++)
      if (ram[i] !== ref_mem[i]) begin
        mism++;
        last = i;
      end
    check("ram_model", mism, 0);
    if (mism != 0) $display("  last differing index %0d", last);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
